spi_master: RTL and testbench

Single-byte SPI master, mode 3 (CPOL=1, CPHA=1), MSB first, for register access to an SPI sensor (e.g. MPU-class IMU). On a `start` pulse it shifts `data_in` out on `mosi` while shifting 8 bits in from `miso`, then presents the received byte on `data_out` with a one-cycle `new_data` strobe. Chip-select is not generated here; the enclosing controller owns CS and transaction sequencing.

---
 rtl/spi_master_if.sv | 34 +++
 rtl/spi_master.sv | 93 +++++++++
 tb/tb_spi_master.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// Byte-level SPI master bus: transfer handshake plus serial pins.
// The master modport is the controller side; slave is the user or bench side.
interface spi_master_if;
  logic       start;
  logic       miso;
  logic [7:0] data_in;
  logic       sck;
  logic       busy;
  logic       new_data;
  logic       mosi;
  logic [7:0] data_out;

  modport master (
    input  start,
    input  miso,
    input  data_in,
    output sck,
    output busy,
    output new_data,
    output mosi,
    output data_out
  );

  modport slave (
    output start,
    output miso,
    output data_in,
    input  sck,
    input  busy,
    input  new_data,
    input  mosi,
    input  data_out
  );
endinterface

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 3, MSB first. Chip-select belongs to the caller.
// Every output comes straight from a flop, so SCK and MOSI cannot glitch.
module spi_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  spi_master_if.master bus
);

  typedef enum logic [0:0] {StIdle, StTransfer} state_e;

  localparam logic [CLK_DIV-1:0] CtrOne  = {{(CLK_DIV-1){1'b0}}, 1'b1};
  localparam logic [CLK_DIV-1:0] CtrHalf = {1'b1, {(CLK_DIV-1){1'b0}}};
  localparam logic [CLK_DIV-1:0] CtrMax  = {CLK_DIV{1'b1}};

  state_e             state_q;
  logic [CLK_DIV-1:0] ctr_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         sr_q;
  logic               rxb_q;
  logic               sck_q;
  logic               busy_q;
  logic               mosi_q;
  logic               new_data_q;
  logic [7:0]         data_out_q;

  logic [CLK_DIV-1:0] ctr_nxt;
  logic [7:0]         sr_shift;

  assign ctr_nxt  = ctr_q + CtrOne;
  assign sr_shift = {sr_q[6:0], rxb_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      ctr_q      <= '0;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      rxb_q      <= 1'b0;
      sck_q      <= 1'b1;
      busy_q     <= 1'b0;
      mosi_q     <= 1'b1;
      new_data_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      new_data_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StTransfer;
            sr_q      <= bus.data_in;
            ctr_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            sck_q     <= 1'b0;
            mosi_q    <= bus.data_in[7];
          end
        end
        StTransfer: begin
          // SCK mirrors the counter MSB: low for the first half of each bit, high for the second.
          ctr_q <= ctr_nxt;
          sck_q <= ctr_nxt[CLK_DIV-1];
          // Sample one clock after SCK rises, well clear of the slave's falling-edge update.
          if (ctr_q == CtrHalf) begin
            rxb_q <= bus.miso;
          end
          if (ctr_q == CtrMax) begin
            sr_q      <= sr_shift;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            mosi_q    <= sr_q[6];
            if (bit_cnt_q == 3'd7) begin
              state_q    <= StIdle;
              data_out_q <= sr_shift;
              new_data_q <= 1'b1;
              busy_q     <= 1'b0;
              sck_q      <= 1'b1;
              mosi_q     <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sck      = sck_q;
  assign bus.busy     = busy_q;
  assign bus.mosi     = mosi_q;
  assign bus.new_data = new_data_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=4, one at CLK_DIV=2 with start held.
// A negedge monitor watches SCK edges, MOSI bits, busy length and new_data strobes.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4;
  logic rst2;

  spi_master_if if4 ();
  spi_master_if if2 ();

  spi_master #(.CLK_DIV(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4));
  spi_master #(.CLK_DIV(2)) dut2 (.clk(clk), .rst(rst2), .bus(if2));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // miso source for the CLK_DIV=4 instance: 0 = tied high, 1 = loopback, 2 = slave model
  logic [1:0] miso_mode;
  logic       slave_bit = 1'b1;
  logic       slave_load;
  logic [7:0] slave_tx;
  logic [7:0] slave_sr;

  assign if4.miso = (miso_mode == 2'd1) ? if4.mosi :
                    (miso_mode == 2'd2) ? slave_bit : 1'b1;
  assign if2.miso = if2.mosi;

  logic       mon_clr;
  logic       sck_prev = 1'b1;
  int         rise_cnt;
  int         fall_cnt;
  int         busy_cnt;
  int         nd_cnt;
  logic [7:0] mosi_bits;
  logic [7:0] nd_dout;

  always @(negedge clk) begin
    sck_prev <= if4.sck;
    // Mode-3 slave: drive the next bit on every SCK falling edge, MSB on the first.
    if (slave_load) begin
      slave_sr  <= slave_tx;
      slave_bit <= slave_tx[7];
    end else if (sck_prev && !if4.sck) begin
      slave_bit <= slave_sr[7];
      slave_sr  <= {slave_sr[6:0], 1'b0};
    end
    if (mon_clr) begin
      rise_cnt  <= 0;
      fall_cnt  <= 0;
      busy_cnt  <= 0;
      nd_cnt    <= 0;
      mosi_bits <= '0;
      nd_dout   <= '0;
    end else begin
      if (!sck_prev && if4.sck) begin
        rise_cnt  <= rise_cnt + 1;
        mosi_bits <= {mosi_bits[6:0], if4.mosi};
      end
      if (sck_prev && !if4.sck) fall_cnt <= fall_cnt + 1;
      if (if4.busy) busy_cnt <= busy_cnt + 1;
      if (if4.new_data) begin
        nd_cnt  <= nd_cnt + 1;
        nd_dout <= if4.data_out;
      end
    end
  end

  logic       mon2_clr;
  logic       sck2_prev = 1'b1;
  logic       nd2_prev;
  int         cyc2;
  int         nd2_cnt;
  int         nd2_last;
  int         nd2_gap_ok;
  int         busy_after_ok;
  int         busy_run;
  int         busy_run_last;
  int         rise2_cnt;
  int         rise2_prev;
  int         gap4_cnt;
  logic [7:0] nd2_dout [4];

  always @(negedge clk) begin
    sck2_prev <= if2.sck;
    nd2_prev  <= if2.new_data;
    if (mon2_clr) begin
      cyc2          <= 0;
      nd2_cnt       <= 0;
      nd2_last      <= 0;
      nd2_gap_ok    <= 0;
      busy_after_ok <= 0;
      busy_run      <= 0;
      busy_run_last <= 0;
      rise2_cnt     <= 0;
      rise2_prev    <= 0;
      gap4_cnt      <= 0;
    end else begin
      cyc2 <= cyc2 + 1;
      if (if2.new_data) begin
        nd2_cnt  <= nd2_cnt + 1;
        nd2_last <= cyc2;
        if (nd2_cnt > 0 && cyc2 - nd2_last == 33) nd2_gap_ok <= nd2_gap_ok + 1;
        if (nd2_cnt < 4) nd2_dout[nd2_cnt[1:0]] <= if2.data_out;
      end
      if (nd2_prev && if2.busy) busy_after_ok <= busy_after_ok + 1;
      if (if2.busy) begin
        busy_run <= busy_run + 1;
      end else if (busy_run != 0) begin
        busy_run_last <= busy_run;
        busy_run      <= 0;
      end
      if (!sck2_prev && if2.sck) begin
        rise2_cnt  <= rise2_cnt + 1;
        rise2_prev <= cyc2;
        if (rise2_cnt > 0 && cyc2 - rise2_prev == 4) gap4_cnt <= gap4_cnt + 1;
      end
    end
  end

  // One transfer on the CLK_DIV=4 instance; rp > 0 re-pulses start with other data mid-transfer.
  task automatic run_xfer(input string tag, input logic [7:0] din, input int pulse, input int rp,
                          input logic [7:0] exp_dout);
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    if4.data_in = din;
    if4.start   = 1'b1;
    tick(pulse);
    if4.start = 1'b0;
    for (int i = 0; i < 400 && nd_cnt == 0; i++) begin
      if (rp > 0 && i == rp) begin
        if4.data_in = 8'h11;
        if4.start   = 1'b1;
      end
      if (rp > 0 && i == rp + 2) if4.start = 1'b0;
      tick(1);
    end
    if4.start = 1'b0;
    tick(20);
    check({tag, "_mosi"}, {24'd0, mosi_bits}, {24'd0, din});
    check({tag, "_rises"}, rise_cnt, 8);
    check({tag, "_falls"}, fall_cnt, 8);
    check({tag, "_busy_len"}, busy_cnt, 128);
    check({tag, "_new_data_cnt"}, nd_cnt, 1);
    check({tag, "_dout_at_strobe"}, {24'd0, nd_dout}, {24'd0, exp_dout});
    check({tag, "_dout_held"}, {24'd0, if4.data_out}, {24'd0, exp_dout});
    check({tag, "_sck_idle"}, {31'd0, if4.sck}, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst4        = 1'b0;
    rst2        = 1'b0;
    if4.start   = 1'b0;
    if4.data_in = '0;
    if2.start   = 1'b0;
    if2.data_in = '0;
    miso_mode   = 2'd0;
    slave_load  = 1'b0;
    slave_tx    = '0;
    mon_clr     = 1'b1;
    mon2_clr    = 1'b1;
    tick(3);

    check("rst_sck", {31'd0, if4.sck}, 1);
    check("rst_busy", {31'd0, if4.busy}, 0);
    check("rst_mosi", {31'd0, if4.mosi}, 1);
    check("rst_new_data", {31'd0, if4.new_data}, 0);
    check("rst_data_out", {24'd0, if4.data_out}, 0);

    rst4 = 1'b1;
    rst2 = 1'b1;
    tick(2);
    mon_clr  = 1'b0;
    mon2_clr = 1'b0;

    run_xfer("b7", 8'hB7, 3, 0, 8'hFF);
    run_xfer("ed", 8'hED, 1, 0, 8'hFF);

    miso_mode = 2'd1;
    run_xfer("loop5a", 8'h5A, 1, 0, 8'h5A);

    slave_tx   = 8'hC3;
    slave_load = 1'b1;
    tick(1);
    slave_load = 1'b0;
    miso_mode  = 2'd2;
    run_xfer("slave_c3", 8'h29, 1, 0, 8'hC3);

    miso_mode = 2'd1;
    run_xfer("restart_ignored", 8'h96, 2, 40, 8'h96);

    // Abort at bit 4 with a loopback transfer of 0xA5.
    mon_clr = 1'b1;
    tick(1);
    mon_clr     = 1'b0;
    if4.data_in = 8'hA5;
    if4.start   = 1'b1;
    tick(1);
    if4.start = 1'b0;
    tick(70);
    check("abort_busy_before", {31'd0, if4.busy}, 1);
    rst4 = 1'b0;
    #1;
    check("abort_sck", {31'd0, if4.sck}, 1);
    check("abort_busy", {31'd0, if4.busy}, 0);
    check("abort_mosi", {31'd0, if4.mosi}, 1);
    check("abort_data_out", {24'd0, if4.data_out}, 0);
    check("abort_new_data", {31'd0, if4.new_data}, 0);
    tick(3);
    rst4 = 1'b1;
    tick(200);
    check("abort_no_strobe", nd_cnt, 0);
    run_xfer("after_abort", 8'h3C, 1, 0, 8'h3C);

    // CLK_DIV=2 with start held: four back-to-back transfers.
    mon2_clr = 1'b1;
    tick(1);
    mon2_clr    = 1'b0;
    if2.data_in = 8'h81;
    if2.start   = 1'b1;
    for (int i = 0; i < 100 && nd2_cnt < 1; i++) tick(1);
    if2.data_in = 8'h42;
    for (int i = 0; i < 200 && nd2_cnt < 3; i++) tick(1);
    if2.start = 1'b0;
    for (int i = 0; i < 100 && nd2_cnt < 4; i++) tick(1);
    tick(10);
    check("div2_strobes", nd2_cnt, 4);
    check("div2_strobe_spacing", nd2_gap_ok, 3);
    check("div2_busy_after_strobe", busy_after_ok, 3);
    check("div2_busy_len", busy_run_last, 32);
    check("div2_rises", rise2_cnt, 32);
    check("div2_sck_period4", gap4_cnt, 28);
    check("div2_dout0", {24'd0, nd2_dout[0]}, 32'h81);
    check("div2_dout1", {24'd0, nd2_dout[1]}, 32'h81);
    check("div2_dout2", {24'd0, nd2_dout[2]}, 32'h42);
    check("div2_dout3", {24'd0, nd2_dout[3]}, 32'h42);
    check("div2_sck_idle", {31'd0, if2.sck}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
